// File: rtl/fifo_rd_pkg.sv
// Shared FSM encoding and default counter width for the FIFO-to-AXI-Stream reader.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    localparam int DEFAULT_LEN_W = 8;

endpackage

// File: rtl/fifo_rd_pkt_ctr.sv
// Packet beat counter with latched length and last-beat prediction for the word being popped.
// Used by fifo_axis_reader only when RD_TLAST_EN is defined.
module fifo_rd_pkt_ctr
    import fifo_rd_pkg::*;
#(
    parameter int LEN_W = DEFAULT_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             accept,
    output logic [LEN_W-1:0] beat_cnt,
    output logic             last_load,
    output logic             at_boundary
);

    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] last_idx;
    logic [LEN_W-1:0] cnt_next;
    logic [LEN_W-1:0] pop_idx;

    assign last_idx = len_q - LEN_W'(1);
    assign cnt_next = (beat_cnt == last_idx) ? '0 : beat_cnt + LEN_W'(1);

    // A pop only happens with the output register empty or being accepted, so the
    // popped word's position is either the current count or the one after it.
    assign pop_idx     = accept ? cnt_next : beat_cnt;
    assign last_load   = (pop_idx == last_idx);
    assign at_boundary = (pop_idx == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q    <= LEN_W'(1);
            beat_cnt <= '0;
        end else if (start) begin
            len_q    <= len;
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/fifo_axis_reader.sv
// Show-ahead FIFO consumer driving a registered AXI-Stream master at one beat per cycle.
// Define RD_TLAST_EN to frame the stream into pkt_len-beat packets with m_tlast.
module fifo_axis_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_W      = DEFAULT_LEN_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    input  logic                  start,
    input  logic                  stop,
    input  logic [LEN_W-1:0]      pkt_len,
    output logic                  m_tvalid,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic                  busy,
    output logic [LEN_W-1:0]      beat_cnt
);

    rd_state_t state, state_nxt;
    logic      stop_pend;
    logic      accept;
    logic      or_free;
    logic      start_acc;
    logic      stop_eff;
    logic      pop_block;
    logic      last_load;

    assign accept    = m_tvalid && m_tready;
    assign or_free   = !m_tvalid || m_tready;
    assign start_acc = (state == IDLE) && start && (pkt_len != '0);
    // A stop arriving this cycle already counts, so it wins over a coincident packet boundary.
    assign stop_eff  = stop_pend || ((state == RUN) && stop);

`ifdef RD_TLAST_EN
    logic at_boundary;

    fifo_rd_pkt_ctr #(
        .LEN_W(LEN_W)
    ) u_pkt_ctr (
        .clk        (clk),
        .rst        (rst),
        .start      (start_acc),
        .len        (pkt_len),
        .accept     (accept),
        .beat_cnt   (beat_cnt),
        .last_load  (last_load),
        .at_boundary(at_boundary)
    );

    assign pop_block = stop_eff && at_boundary;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (start_acc) begin
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
        end
    end

    assign last_load = 1'b0;
    assign pop_block = stop_eff;
`endif

    assign fifo_rd_en = !rst && (state == RUN) && !pop_block && !fifo_empty && or_free;
    assign busy       = (state == RUN) || (state == DRAIN);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_acc) state_nxt = RUN;
            RUN:     if (pop_block) state_nxt = DRAIN;
            DRAIN:   if (or_free)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            stop_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == DRAIN) && (state_nxt == IDLE)) begin
                stop_pend <= 1'b0;
            end else if ((state == RUN) && stop) begin
                stop_pend <= 1'b1;
            end
        end
    end

    // Output register: load on pop, empty on acceptance without refill, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
        end else if (fifo_rd_en) begin
            m_tvalid <= 1'b1;
            m_tdata  <= fifo_data;
            m_tlast  <= last_load;
        end else if (accept) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end
    end

endmodule
